// File: rtl/sha256_msg_pad.sv
// SHA-256 message padder: packs 32-bit message words into 512-bit blocks and drives an external compression core.
// Optional macro SHA224_MODE_EN adds i_sha224 to select the SHA-224 IV and truncated digest.
`timescale 1ns/1ps
module sha256_msg_pad (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_init,
`ifdef SHA224_MODE_EN
   input  logic         i_sha224,
`endif
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [31:0]  i_data,
   input  logic         i_last,
   input  logic [2:0]   i_nbytes,
   output logic [511:0] o_blk,
   output logic [255:0] o_vin,
   output logic         o_start,
   input  logic         i_core_done,
   input  logic [255:0] i_core_vout,
   output logic [255:0] o_digest,
   output logic         o_digest_valid,
   output logic         o_busy
);

   localparam int unsigned WORD_W = 32;
   localparam int unsigned NWORDS = 16;
   localparam int unsigned IDX_W  = 4;
   localparam int unsigned CNT_W  = 64;

   localparam logic [255:0] SHA256_IV =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
`ifdef SHA224_MODE_EN
   localparam logic [255:0] SHA224_IV =
      256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
`endif

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PAD, S_RUN, S_WAIT} state_t;

   state_t                       state;
   logic [NWORDS-1:0][WORD_W-1:0] blk;
   logic [IDX_W-1:0]             idx;
   logic [CNT_W-1:0]             byte_cnt;
   logic                         last_seen;  // final data word consumed
   logic                         mark_pend;  // 0x80000000 word still to be placed
   logic                         len_fits;   // current block carries the length
   logic                         len_done;   // length written into current block
`ifdef SHA224_MODE_EN
   logic                         sha224;
`endif

   logic [WORD_W-1:0] tail_word;
   logic [WORD_W-1:0] pad_word;
   logic [CNT_W-1:0]  bit_len;

   assign o_blk   = blk;
   assign bit_len = byte_cnt << 3;

   // Final data word: keep valid bytes, append 0x80, zero the rest.
   always_comb begin
      tail_word = i_data;
      case (i_nbytes)
         3'd0:    tail_word = 32'h8000_0000;
         3'd1:    tail_word = {i_data[31:24], 24'h80_0000};
         3'd2:    tail_word = {i_data[31:16], 16'h8000};
         3'd3:    tail_word = {i_data[31:8], 8'h80};
         default: tail_word = i_data;
      endcase
   end

   always_comb begin
      pad_word = '0;
      if (mark_pend)                     pad_word = 32'h8000_0000;
      else if (len_fits && idx == 4'd14) pad_word = bit_len[63:32];
      else if (len_fits && idx == 4'd15) pad_word = bit_len[31:0];
   end

   // Word k lives at blk[15-k] so word 0 lands in o_blk[511:480]; ~idx == 15-idx.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state          <= S_IDLE;
         blk            <= '0;
         idx            <= '0;
         byte_cnt       <= '0;
         last_seen      <= 1'b0;
         mark_pend      <= 1'b0;
         len_fits       <= 1'b0;
         len_done       <= 1'b0;
         o_vin          <= '0;
         o_digest       <= '0;
         o_ready        <= 1'b0;
         o_start        <= 1'b0;
         o_digest_valid <= 1'b0;
         o_busy         <= 1'b0;
`ifdef SHA224_MODE_EN
         sha224         <= 1'b0;
`endif
      end else begin
         o_start        <= 1'b0;
         o_digest_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (i_init) begin
`ifdef SHA224_MODE_EN
                  o_vin  <= i_sha224 ? SHA224_IV : SHA256_IV;
                  sha224 <= i_sha224;
`else
                  o_vin  <= SHA256_IV;
`endif
                  blk       <= '0;
                  idx       <= '0;
                  byte_cnt  <= '0;
                  last_seen <= 1'b0;
                  mark_pend <= 1'b0;
                  len_fits  <= 1'b0;
                  len_done  <= 1'b0;
                  o_ready   <= 1'b1;
                  o_busy    <= 1'b1;
                  state     <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (i_valid && o_ready) begin
                  byte_cnt <= byte_cnt + CNT_W'(i_nbytes);
                  idx      <= idx + 4'd1;
                  if (i_last) begin
                     blk[~idx] <= tail_word;
                     last_seen <= 1'b1;
                     mark_pend <= (i_nbytes == 3'd4);
                     len_fits  <= (i_nbytes != 3'd4) && (idx <= 4'd13);
                     o_ready   <= 1'b0;
                     state     <= (idx == 4'd15) ? S_RUN : S_PAD;
                  end else begin
                     blk[~idx] <= i_data;
                     if (idx == 4'd15) begin
                        o_ready <= 1'b0;
                        state   <= S_RUN;
                     end
                  end
               end
            end
            S_PAD: begin
               blk[~idx] <= pad_word;
               idx       <= idx + 4'd1;
               if (mark_pend) begin
                  mark_pend <= 1'b0;
                  len_fits  <= (idx <= 4'd13);
               end
               if (idx == 4'd15) begin
                  len_done <= len_fits && !mark_pend;
                  state    <= S_RUN;
               end
            end
            S_RUN: begin
               o_start <= 1'b1;
               state   <= S_WAIT;
            end
            S_WAIT: begin
               if (i_core_done) begin
                  o_vin <= i_core_vout;
                  idx   <= '0;
                  if (!last_seen) begin
                     o_ready <= 1'b1;
                     state   <= S_LOAD;
                  end else if (len_done) begin
`ifdef SHA224_MODE_EN
                     o_digest <= sha224 ? {i_core_vout[255:32], 32'h0} : i_core_vout;
`else
                     o_digest <= i_core_vout;
`endif
                     o_digest_valid <= 1'b1;
                     o_busy         <= 1'b0;
                     state          <= S_IDLE;
                  end else begin
                     len_fits <= 1'b1;
                     state    <= S_PAD;
                  end
               end
            end
            default: begin
               o_ready <= 1'b0;
               o_busy  <= 1'b0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_msg_pad.sv
// Directed bench for sha256_msg_pad with a behavioural SHA-256 compression core.
`timescale 1ns/1ps
module tb_sha256_msg_pad;

   typedef logic [7:0] bytes_t[$];

   logic         i_clk = 1'b0;
   logic         i_rst_n = 1'b0;
   logic         i_init = 1'b0;
   logic         i_valid = 1'b0;
   logic         i_last = 1'b0;
   logic [31:0]  i_data = '0;
   logic [2:0]   i_nbytes = '0;
   logic         i_core_done = 1'b0;
   logic [255:0] i_core_vout = '0;
`ifdef SHA224_MODE_EN
   logic         i_sha224 = 1'b0;
`endif
   logic         o_ready, o_start, o_digest_valid, o_busy;
   logic [511:0] o_blk;
   logic [255:0] o_vin, o_digest;

   int n_vec = 0;
   int n_bad = 0;
   int starts = 0;
   int dv_cnt = 0;
   int stab_bad = 0;
   int stray_req = 0;
   int stray_ack = 0;
   bit core_en = 1'b1;
   logic [511:0] cap_blk[$];
   logic [255:0] dig_seen = '0;

   localparam logic [255:0] IV256 =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [255:0] EXP_ABC =
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] EXP_EMPTY =
      256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] EXP_56 =
      256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   sha256_msg_pad dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_init(i_init),
`ifdef SHA224_MODE_EN
      .i_sha224(i_sha224),
`endif
      .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data), .i_last(i_last),
      .i_nbytes(i_nbytes), .o_blk(o_blk), .o_vin(o_vin), .o_start(o_start),
      .i_core_done(i_core_done), .i_core_vout(i_core_vout), .o_digest(o_digest),
      .o_digest_valid(o_digest_valid), .o_busy(o_busy));

   always #5 i_clk = ~i_clk;

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] b);
      logic [31:0] w [0:63];
      logic [31:0] a, bb, c, d, e, f, g, h, s0, s1, t1, t2;
      for (int t = 0; t < 16; t++) w[t] = b[511 - 32*t -: 32];
      for (int t = 16; t < 64; t++) begin
         s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
         s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
         w[t] = w[t-16] + s0 + w[t-7] + s1;
      end
      {a, bb, c, d, e, f, g, h} = hin;
      for (int t = 0; t < 64; t++) begin
         t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
         t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & bb) ^ (a & c) ^ (bb & c));
         h = g; g = f; f = e; e = d + t1; d = c; c = bb; bb = a; a = t1 + t2;
      end
      return {hin[255:224] + a, hin[223:192] + bb, hin[191:160] + c, hin[159:128] + d,
              hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
   endfunction

   // Behavioural hash core: answers each o_start three cycles later; also injects stray done pulses.
   always begin : core_model
      logic [511:0] b;
      logic [255:0] v;
      @(posedge i_clk); #1;
      if (stray_req != stray_ack) begin
         i_core_vout = {8{32'hdeadbeef}};
         i_core_done = 1'b1;
         @(posedge i_clk); #1;
         i_core_done = 1'b0;
         stray_ack = stray_req;
      end else if (o_start) begin
         cap_blk.push_back(o_blk);
         starts++;
         if (core_en) begin
            b = o_blk;
            v = o_vin;
            repeat (3) @(posedge i_clk);
            #1;
            if (o_blk !== b || o_vin !== v) stab_bad++;
            i_core_vout = sha_compress(v, b);
            i_core_done = 1'b1;
            @(posedge i_clk); #1;
            i_core_done = 1'b0;
         end
      end
   end

   always begin : digest_monitor
      @(posedge i_clk); #1;
      if (o_digest_valid) begin
         dv_cnt++;
         dig_seen = o_digest;
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic bytes_t str2q(input string s);
      bytes_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      return q;
   endfunction

   task automatic do_init();
      i_init = 1'b1;
      @(posedge i_clk); #1;
      i_init = 1'b0;
   endtask

   // Streams a message as words; unused byte lanes carry junk to exercise masking.
   task automatic send_msg(input bytes_t m, input int init_at);
      int len, nw, nb, t;
      logic [31:0] w;
      len = m.size();
      nw  = (len == 0) ? 1 : (len + 3) / 4;
      for (int k = 0; k < nw; k++) begin
         if (k == init_at) do_init();
         nb = len - 4*k;
         if (nb > 4) nb = 4;
         w = 32'hA5A5A5A5;
         for (int j = 0; j < nb; j++) w[31 - 8*j -: 8] = m[4*k + j];
         i_data   = w;
         i_nbytes = 3'(nb);
         i_last   = (k == nw - 1);
         i_valid  = 1'b1;
         t = 0;
         while (!o_ready && t < 500) begin
            @(posedge i_clk); #1;
            t++;
         end
         @(posedge i_clk); #1;
         i_valid = 1'b0;
         i_last  = 1'b0;
      end
   endtask

   task automatic wait_dv(input int base, output bit ok);
      int t = 0;
      while (dv_cnt == base && t < 3000) begin
         @(posedge i_clk); #1;
         t++;
      end
      ok = (dv_cnt != base);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge i_clk);
      #1;
      n_vec++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got=%b exp=0", o_ready); end
      n_vec++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
      n_vec++; if (o_start !== 1'b0) begin n_bad++; $display("FAIL reset_start got=%b exp=0", o_start); end
      n_vec++; if (o_digest_valid !== 1'b0) begin n_bad++; $display("FAIL reset_dv got=%b exp=0", o_digest_valid); end
      n_vec++; if (o_blk !== '0) begin n_bad++; $display("FAIL reset_blk got=%h exp=0", o_blk); end
      n_vec++; if (o_vin !== '0) begin n_bad++; $display("FAIL reset_vin got=%h exp=0", o_vin); end
      n_vec++; if (o_digest !== '0) begin n_bad++; $display("FAIL reset_digest got=%h exp=0", o_digest); end
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;
   endtask

   task automatic test_idle_valid();
      int s0 = starts;
      i_valid = 1'b1; i_last = 1'b1; i_nbytes = 3'd3; i_data = 32'h61626300;
      for (int c = 0; c < 4; c++) begin
         @(posedge i_clk); #1;
         n_vec++; if (o_ready !== 1'b0 || o_busy !== 1'b0) begin
            n_bad++; $display("FAIL idle_valid_ignored cyc=%0d ready=%b busy=%b exp=0,0", c, o_ready, o_busy);
         end
      end
      i_valid = 1'b0; i_last = 1'b0;
      repeat (6) @(posedge i_clk);
      #1;
      n_vec++; if (starts != s0) begin n_bad++; $display("FAIL idle_no_start got=%0d exp=%0d", starts, s0); end
   endtask

   task automatic test_abc();
      int s0 = starts, d0 = dv_cnt;
      bit ok;
      do_init();
      n_vec++; if (o_vin !== IV256) begin n_bad++; $display("FAIL abc_iv got=%h exp=%h", o_vin, IV256); end
      n_vec++; if (o_ready !== 1'b1 || o_busy !== 1'b1) begin n_bad++; $display("FAIL abc_load_flags ready=%b busy=%b exp=1,1", o_ready, o_busy); end
      send_msg(str2q("abc"), -1);
      wait_dv(d0, ok);
      n_vec++; if (!ok) begin n_bad++; $display("FAIL abc_timeout got=no digest exp=digest pulse"); end
      n_vec++; if (dig_seen !== EXP_ABC) begin n_bad++; $display("FAIL abc_digest got=%h exp=%h", dig_seen, EXP_ABC); end
      n_vec++; if (starts - s0 != 1) begin n_bad++; $display("FAIL abc_starts got=%0d exp=1", starts - s0); end
      if (cap_blk.size() > s0) begin
         n_vec++; if (cap_blk[s0][511:480] !== 32'h61626380) begin n_bad++; $display("FAIL abc_word0 got=%h exp=61626380", cap_blk[s0][511:480]); end
         n_vec++; if (cap_blk[s0][63:0] !== 64'h18) begin n_bad++; $display("FAIL abc_len got=%h exp=18", cap_blk[s0][63:0]); end
      end
      @(posedge i_clk); #1;
      n_vec++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL abc_idle_busy got=%b exp=0", o_busy); end
   endtask

   task automatic test_empty();
      int s0 = starts, d0 = dv_cnt;
      bit ok;
      bytes_t q;
      do_init();
      send_msg(q, -1);
      wait_dv(d0, ok);
      n_vec++; if (!ok || dig_seen !== EXP_EMPTY) begin n_bad++; $display("FAIL empty_digest got=%h exp=%h", dig_seen, EXP_EMPTY); end
      n_vec++; if (starts - s0 != 1) begin n_bad++; $display("FAIL empty_starts got=%0d exp=1", starts - s0); end
      if (cap_blk.size() > s0) begin
         n_vec++; if (cap_blk[s0][511:480] !== 32'h80000000) begin n_bad++; $display("FAIL empty_word0 got=%h exp=80000000", cap_blk[s0][511:480]); end
         n_vec++; if (cap_blk[s0][63:0] !== 64'h0) begin n_bad++; $display("FAIL empty_len got=%h exp=0", cap_blk[s0][63:0]); end
      end
   endtask

   task automatic test_two_block_56();
      int s0 = starts, d0 = dv_cnt;
      bit ok;
      do_init();
      send_msg(str2q("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"), -1);
      wait_dv(d0, ok);
      n_vec++; if (!ok || dig_seen !== EXP_56) begin n_bad++; $display("FAIL m56_digest got=%h exp=%h", dig_seen, EXP_56); end
      n_vec++; if (starts - s0 != 2) begin n_bad++; $display("FAIL m56_starts got=%0d exp=2", starts - s0); end
      if (cap_blk.size() > s0 + 1) begin
         n_vec++; if (cap_blk[s0][63:0] !== 64'h80000000_00000000) begin n_bad++; $display("FAIL m56_blk1_tail got=%h exp=8000000000000000", cap_blk[s0][63:0]); end
         n_vec++; if (cap_blk[s0+1] !== 512'h1c0) begin n_bad++; $display("FAIL m56_blk2 got=%h exp=1c0", cap_blk[s0+1]); end
      end
   endtask

   task automatic test_64_with_stray_init();
      int s0 = starts, d0 = dv_cnt;
      bit ok;
      bytes_t q;
      for (int i = 0; i < 64; i++) q.push_back(8'(i));
      do_init();
      send_msg(q, 8);
      wait_dv(d0, ok);
      n_vec++; if (!ok) begin n_bad++; $display("FAIL m64_timeout got=no digest exp=digest pulse"); end
      n_vec++; if (starts - s0 != 2) begin n_bad++; $display("FAIL m64_starts got=%0d exp=2", starts - s0); end
      if (cap_blk.size() > s0 + 1) begin
         n_vec++; if (cap_blk[s0][31:0] !== 32'h3c3d3e3f) begin n_bad++; $display("FAIL m64_blk1_w15 got=%h exp=3c3d3e3f", cap_blk[s0][31:0]); end
         n_vec++; if (cap_blk[s0+1][511:480] !== 32'h80000000) begin n_bad++; $display("FAIL m64_blk2_w0 got=%h exp=80000000", cap_blk[s0+1][511:480]); end
         n_vec++; if (cap_blk[s0+1][31:0] !== 32'h00000200) begin n_bad++; $display("FAIL m64_blk2_w15 got=%h exp=00000200", cap_blk[s0+1][31:0]); end
      end
   endtask

   task automatic test_reset_in_wait();
      int s0 = starts, d0, t = 0;
      core_en = 1'b0;
      do_init();
      send_msg(str2q("abc"), -1);
      while (starts == s0 && t < 200) begin @(posedge i_clk); #1; t++; end
      n_vec++; if (starts == s0) begin n_bad++; $display("FAIL rstw_start got=no start exp=start"); end
      repeat (2) @(posedge i_clk);
      #1;
      i_rst_n = 1'b0;
      #1;
      n_vec++; if (o_busy !== 1'b0 || o_vin !== '0) begin n_bad++; $display("FAIL rstw_async busy=%b vin=%h exp=0,0", o_busy, o_vin); end
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;
      d0 = dv_cnt;
      stray_req++;
      repeat (6) @(posedge i_clk);
      #1;
      n_vec++; if (dv_cnt != d0) begin n_bad++; $display("FAIL rstw_stray_dv got=%0d exp=%0d", dv_cnt, d0); end
      n_vec++; if (o_busy !== 1'b0 || o_vin !== '0) begin n_bad++; $display("FAIL rstw_stray_state busy=%b vin=%h exp=0,0", o_busy, o_vin); end
      core_en = 1'b1;
      test_abc();
   endtask

`ifdef SHA224_MODE_EN
   task automatic test_sha224();
      int d0 = dv_cnt;
      bit ok;
      i_sha224 = 1'b1;
      do_init();
      i_sha224 = 1'b0;
      send_msg(str2q("abc"), -1);
      wait_dv(d0, ok);
      n_vec++; if (!ok || dig_seen !== 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000) begin
         n_bad++; $display("FAIL sha224_abc got=%h", dig_seen);
      end
   endtask
`endif

   task automatic test_core_inputs_stable();
      n_vec++; if (stab_bad != 0) begin n_bad++; $display("FAIL blk_vin_stable got=%0d changes exp=0", stab_bad); end
   endtask

   initial begin
      test_reset();
      test_idle_valid();
      test_abc();
      test_empty();
      test_two_block_56();
      test_64_with_stray_init();
      test_reset_in_wait();
`ifdef SHA224_MODE_EN
      test_sha224();
`endif
      test_core_inputs_stable();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
